// File: rtl/add_sub_rr_arbiter.sv
// Round-robin arbiter sharing one add/sub datapath between NUM_REQ requesters.
// The winner's result lands in a one-entry valid/ready output register that can be drained and refilled in the same cycle.
module add_sub_rr_arbiter #(
    parameter int NUM_REQ = 4,
    parameter int DATA_W  = 3,
    parameter int OUT_W   = DATA_W + 1,
    parameter int ID_W    = 2
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic [NUM_REQ-1:0]        req,
    input  logic [NUM_REQ*DATA_W-1:0] req_a,
    input  logic [NUM_REQ*DATA_W-1:0] req_b,
    input  logic [NUM_REQ-1:0]        req_sub,
    output logic [NUM_REQ-1:0]        gnt,
    output logic                      res_valid,
    input  logic                      res_ready,
    output logic [OUT_W-1:0]          res_data,
    output logic [ID_W-1:0]           res_id,
    output logic                      res_sub
);

    logic [DATA_W-1:0] a_arr [NUM_REQ];
    logic [DATA_W-1:0] b_arr [NUM_REQ];

    logic [ID_W-1:0]  ptr_reg;
    logic [ID_W-1:0]  ptr_next;
    logic [ID_W-1:0]  winner;
    logic [ID_W:0]    cand;
    logic             found;
    logic             accept;
    logic             valid_reg;
    logic [OUT_W-1:0] data_reg;
    logic [ID_W-1:0]  id_reg;
    logic             sub_reg;
    logic [OUT_W-1:0] a_ext;
    logic [OUT_W-1:0] b_ext;
    logic             sub_sel;
    logic [OUT_W-1:0] data_next;

    generate
        for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_req
            assign a_arr[gi] = req_a[gi*DATA_W +: DATA_W];
            assign b_arr[gi] = req_b[gi*DATA_W +: DATA_W];
            assign gnt[gi]   = accept && (winner == ID_W'(gi));
        end
    endgenerate

    // Scan from the pointer, wrapping modulo NUM_REQ; the first asserted request wins.
    always_comb begin
        found  = 1'b0;
        winner = '0;
        cand   = '0;
        for (int off = 0; off < NUM_REQ; off++) begin
            cand = {1'b0, ptr_reg} + (ID_W+1)'(off);
            if (cand >= (ID_W+1)'(NUM_REQ)) begin
                cand = cand - (ID_W+1)'(NUM_REQ);
            end
            if (!found && req[cand[ID_W-1:0]]) begin
                found  = 1'b1;
                winner = cand[ID_W-1:0];
            end
        end
    end

    // Gated by rst_n so no requester sees a grant while reset is held.
    assign accept = rst_n && found && (!valid_reg || res_ready);

    assign ptr_next  = (winner == ID_W'(NUM_REQ-1)) ? '0 : winner + 1'b1;
    assign a_ext     = OUT_W'(a_arr[winner]);
    assign b_ext     = OUT_W'(b_arr[winner]);
    assign sub_sel   = req_sub[winner];
    assign data_next = sub_sel ? (a_ext - b_ext) : (a_ext + b_ext);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ptr_reg   <= '0;
            valid_reg <= 1'b0;
            data_reg  <= '0;
            id_reg    <= '0;
            sub_reg   <= 1'b0;
        end else if (accept) begin
            ptr_reg   <= ptr_next;
            valid_reg <= 1'b1;
            data_reg  <= data_next;
            id_reg    <= winner;
            sub_reg   <= sub_sel;
        end else if (res_ready) begin
            valid_reg <= 1'b0;
        end
    end

    assign res_valid = valid_reg;
    assign res_data  = data_reg;
    assign res_id    = id_reg;
    assign res_sub   = sub_reg;

endmodule

// File: tb/tb_add_sub_rr_arbiter.sv
// Randomised and directed bench for add_sub_rr_arbiter against a queue-free arithmetic reference model.
module tb_add_sub_rr_arbiter;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [3:0]  req;
    logic [11:0] req_a;
    logic [11:0] req_b;
    logic [3:0]  req_sub;
    logic [3:0]  gnt;
    logic        res_valid;
    logic        res_ready;
    logic [3:0]  res_data;
    logic [1:0]  res_id;
    logic        res_sub;

    int n_vec = 0;
    int n_err = 0;

    // reference model state
    int   ta [4];
    int   tb_ [4];
    bit   ts [4];
    int   m_ptr, m_data, m_id;
    bit   m_valid, m_sub;
    int   exp_win;
    bit   exp_acc;
    logic [3:0] exp_gnt;

    always #5 clk = ~clk;

    add_sub_rr_arbiter dut (
        .clk(clk), .rst_n(rst_n), .req(req), .req_a(req_a), .req_b(req_b),
        .req_sub(req_sub), .gnt(gnt), .res_valid(res_valid), .res_ready(res_ready),
        .res_data(res_data), .res_id(res_id), .res_sub(res_sub)
    );

    function automatic int find_winner(input logic [3:0] r, input int p);
        for (int k = 0; k < 4; k++) begin
            if (r[(p + k) % 4]) return (p + k) % 4;
        end
        return -1;
    endfunction

    task automatic model_reset();
        m_ptr = 0; m_valid = 0; m_data = 0; m_id = 0; m_sub = 0; exp_acc = 0;
    endtask

    task automatic set_op(input int i, input int a, input int b, input bit s);
        ta[i] = a; tb_[i] = b; ts[i] = s;
    endtask

    task automatic rand_ops();
        for (int i = 0; i < 4; i++) set_op(i, $urandom_range(0, 7), $urandom_range(0, 7), 1'($urandom_range(0, 1)));
    endtask

    task automatic apply(input logic [3:0] r, input logic rdy);
        req = r;
        res_ready = rdy;
        for (int i = 0; i < 4; i++) begin
            req_a[i*3 +: 3] = 3'(ta[i]);
            req_b[i*3 +: 3] = 3'(tb_[i]);
            req_sub[i]      = ts[i];
        end
        #1;
        exp_win = find_winner(r, m_ptr);
        exp_acc = (exp_win >= 0) && (!m_valid || rdy);
        exp_gnt = exp_acc ? 4'(1 << exp_win) : 4'b0;
    endtask

    task automatic tick();
        @(posedge clk);
        if (exp_acc) begin
            m_data  = ts[exp_win] ? ((ta[exp_win] - tb_[exp_win]) & 15) : (ta[exp_win] + tb_[exp_win]);
            m_id    = exp_win;
            m_sub   = ts[exp_win];
            m_valid = 1;
            m_ptr   = (exp_win + 1) % 4;
        end else if (res_ready) begin
            m_valid = 0;
        end
        #1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        rand_ops();
        apply(4'b1111, 1'b1);
        repeat (2) @(posedge clk);
        #2;
        n_vec++; if (gnt !== 4'b0) begin n_err++; $display("FAIL reset_gnt got=%b want=0000", gnt); end
        n_vec++; if (res_valid !== 1'b0) begin n_err++; $display("FAIL reset_valid got=%b want=0", res_valid); end
        n_vec++; if (res_data !== 4'd0) begin n_err++; $display("FAIL reset_data got=%h want=0", res_data); end
        n_vec++; if (res_id !== 2'd0 || res_sub !== 1'b0) begin n_err++; $display("FAIL reset_id_sub got=%0d/%b want=0/0", res_id, res_sub); end
        rst_n = 1'b1;
        model_reset();
        apply(4'b1111, 1'b1);
        n_vec++; if (gnt !== 4'b0001) begin n_err++; $display("FAIL reset_first_gnt got=%b want=0001", gnt); end
        tick();
        $display("reset: first grant gnt=0001 res_id=%0d", res_id);
    endtask

    task automatic test_round_robin();
        for (int k = 0; k < 8; k++) begin
            rand_ops();
            apply(4'b1111, 1'b1);
            n_vec++; if (gnt !== exp_gnt) begin n_err++; $display("FAIL rr_gnt[%0d] got=%b want=%b", k, gnt, exp_gnt); end
            tick();
            n_vec++; if (res_id !== 2'(m_id) || res_data !== 4'(m_data) || res_valid !== 1'b1)
                begin n_err++; $display("FAIL rr_res[%0d] got id=%0d data=%h v=%b want id=%0d data=%h v=1", k, res_id, res_data, res_valid, m_id, m_data); end
            $display("rr: cycle %0d gnt=%b res_id=%0d res_data=%h", k, exp_gnt, res_id, res_data);
        end
    endtask

    task automatic test_arith();
        rand_ops();
        set_op(2, 7, 7, 1'b0);
        apply(4'b0100, 1'b1);
        tick();
        n_vec++; if (res_data !== 4'd14 || res_id !== 2'd2) begin n_err++; $display("FAIL arith_7p7 got data=%h id=%0d want data=e id=2", res_data, res_id); end
        set_op(2, 2, 5, 1'b1);
        apply(4'b0100, 1'b1);
        tick();
        n_vec++; if (res_data !== 4'b1101 || res_sub !== 1'b1) begin n_err++; $display("FAIL arith_2m5 got data=%b sub=%b want data=1101 sub=1", res_data, res_sub); end
        set_op(2, 0, 7, 1'b1);
        apply(4'b0100, 1'b1);
        tick();
        n_vec++; if (res_data !== 4'b1001) begin n_err++; $display("FAIL arith_0m7 got data=%b want=1001", res_data); end
        $display("arith: 7+7=e 2-5=1101 0-7=1001 checked, last res_data=%b", res_data);
    endtask

    task automatic test_backpressure();
        logic [3:0] held_data;
        logic [1:0] held_id;
        rand_ops();
        apply(4'b0110, 1'b1);
        tick();
        held_data = 4'(m_data);
        held_id   = 2'(m_id);
        for (int k = 0; k < 5; k++) begin
            rand_ops();
            apply(4'b0110, 1'b0);
            n_vec++; if (gnt !== 4'b0000) begin n_err++; $display("FAIL bp_gnt[%0d] got=%b want=0000", k, gnt); end
            tick();
            n_vec++; if (res_valid !== 1'b1 || res_data !== held_data || res_id !== held_id)
                begin n_err++; $display("FAIL bp_hold[%0d] got v=%b data=%h id=%0d want v=1 data=%h id=%0d", k, res_valid, res_data, res_id, held_data, held_id); end
        end
        apply(4'b0110, 1'b1);
        n_vec++; if (gnt !== exp_gnt || gnt == 4'b0) begin n_err++; $display("FAIL bp_release_gnt got=%b want=%b", gnt, exp_gnt); end
        tick();
        n_vec++; if (res_valid !== 1'b1 || res_data !== 4'(m_data) || res_id !== 2'(m_id))
            begin n_err++; $display("FAIL bp_refill got v=%b data=%h id=%0d want v=1 data=%h id=%0d", res_valid, res_data, res_id, m_data, m_id); end
        $display("backpressure: 5 stalled cycles then refill res_id=%0d", res_id);
    endtask

    task automatic test_wrap_skip();
        rand_ops();
        apply(4'b1000, 1'b1);
        tick();
        apply(4'b0100, 1'b1);
        n_vec++; if (gnt !== 4'b0100) begin n_err++; $display("FAIL wrap_gnt got=%b want=0100", gnt); end
        tick();
        apply(4'b0011, 1'b1);
        n_vec++; if (gnt !== 4'b0001) begin n_err++; $display("FAIL skip_gnt got=%b want=0001", gnt); end
        tick();
        $display("wrap_skip: gnt 1000 -> 0100 -> 0001");
    endtask

    task automatic test_async_reset();
        rand_ops();
        apply(4'b0010, 1'b1);
        tick();
        apply(4'b0000, 1'b0);
        rst_n = 1'b0;
        #1;
        n_vec++; if (res_valid !== 1'b0 || res_data !== 4'd0) begin n_err++; $display("FAIL async_rst got v=%b data=%h want v=0 data=0", res_valid, res_data); end
        model_reset();
        #1;
        rst_n = 1'b1;
        apply(4'b1111, 1'b1);
        n_vec++; if (gnt !== 4'b0001) begin n_err++; $display("FAIL async_rst_ptr got=%b want=0001", gnt); end
        tick();
        $display("async_reset: valid dropped mid-cycle, next gnt=0001");
    endtask

    task automatic test_random();
        for (int k = 0; k < 400; k++) begin
            rand_ops();
            apply(4'($urandom_range(0, 15)), ($urandom_range(0, 3) != 0));
            n_vec++; if (gnt !== exp_gnt) begin n_err++; $display("FAIL rand_gnt[%0d] got=%b want=%b", k, gnt, exp_gnt); end
            tick();
            n_vec++; if (res_valid !== m_valid || (m_valid && (res_data !== 4'(m_data) || res_id !== 2'(m_id) || res_sub !== m_sub)))
                begin n_err++; $display("FAIL rand_res[%0d] got v=%b d=%h id=%0d s=%b want v=%b d=%h id=%0d s=%b", k, res_valid, res_data, res_id, res_sub, m_valid, m_data, m_id, m_sub); end
            $display("rand[%0d]: req=%b rdy=%b gnt=%b v=%b data=%h id=%0d", k, req, res_ready, exp_gnt, res_valid, res_data, res_id);
        end
    endtask

    initial begin
        req = '0; req_a = '0; req_b = '0; req_sub = '0; res_ready = 1'b0;
        model_reset();
        test_reset();
        test_round_robin();
        test_arith();
        test_backpressure();
        test_wrap_skip();
        test_async_reset();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
